// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Builds RV32I instruction words from field-level requests and queues them
//   for the core's fetch/inject port. Requests with illegal field
//   combinations are consumed, never queued, and counted as errors.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           synchronous FIFO clear; the request presented this cycle is dropped
//   req_*           request handshake and instruction fields
//   instr_valid/ready/data  output handshake, data is the FIFO head (0 when empty)
//   encode_error    one-cycle pulse after an illegal request is accepted
//   error_count     saturating count of illegal requests since reset
//   fifo_count      number of occupied FIFO entries
module instruction_encoder #(
    parameter int DEPTH     = 4,
    parameter int ERR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_kind,
    input  logic [4:0]               req_rd,
    input  logic [4:0]               req_rs1,
    input  logic [4:0]               req_rs2,
    input  logic [2:0]               req_funct3,
    input  logic                     req_alt,
    input  logic [31:0]              req_imm,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_data,
    output logic                     encode_error,
    output logic [ERR_WIDTH-1:0]     error_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ALUIMM = 7'b0010011;
    localparam logic [6:0] OPC_ALU    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             encode_error_q, encode_error_d;
    logic [ERR_WIDTH-1:0] error_count_q, error_count_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        imm_s12_ok, imm_s13_ok, imm_s21_ok;
    logic        accept, push, pop;

    // Signed-range checks: the immediate fits when all bits above the sign
    // bit of the target width are copies of that sign bit.
    assign imm_s12_ok = (req_imm[31:11] == '0) || (req_imm[31:11] == '1);
    assign imm_s13_ok = (req_imm[31:12] == '0) || (req_imm[31:12] == '1);
    assign imm_s21_ok = (req_imm[31:20] == '0) || (req_imm[31:20] == '1);

    // Field assembly and legality per instruction kind. Branch and jump
    // offsets are scrambled into the B/J formats; shifts carry shamt in rs2.
    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        case (req_kind)
            4'd0: begin
                enc_word    = {req_imm[31:12], req_rd, OPC_LUI};
                enc_illegal = (req_imm[11:0] != '0);
            end
            4'd1: begin
                enc_word    = {req_imm[31:12], req_rd, OPC_AUIPC};
                enc_illegal = (req_imm[11:0] != '0);
            end
            4'd2: begin
                enc_word    = {req_imm[20], req_imm[10:1], req_imm[11],
                               req_imm[19:12], req_rd, OPC_JAL};
                enc_illegal = !imm_s21_ok || req_imm[0];
            end
            4'd3: begin
                enc_word    = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
                enc_illegal = !imm_s12_ok;
            end
            4'd4: begin
                enc_word    = {req_imm[12], req_imm[10:5], req_rs2, req_rs1,
                               req_funct3, req_imm[4:1], req_imm[11], OPC_BRANCH};
                enc_illegal = !imm_s13_ok || req_imm[0] ||
                              (req_funct3 == 3'b010) || (req_funct3 == 3'b011);
            end
            4'd5: begin
                enc_word    = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
                enc_illegal = !imm_s12_ok || (req_funct3 == 3'b011) ||
                              (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
            end
            4'd6: begin
                enc_word    = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                               req_imm[4:0], OPC_STORE};
                enc_illegal = !imm_s12_ok || (req_funct3 > 3'b010);
            end
            4'd7: begin
                if ((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) begin
                    enc_word    = {1'b0, req_alt, 5'b00000, req_imm[4:0], req_rs1,
                                   req_funct3, req_rd, OPC_ALUIMM};
                    enc_illegal = (req_imm[31:5] != '0) ||
                                  (req_alt && (req_funct3 == 3'b001));
                end else begin
                    enc_word    = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_ALUIMM};
                    enc_illegal = !imm_s12_ok || req_alt;
                end
            end
            4'd8: begin
                enc_word    = {1'b0, req_alt, 5'b00000, req_rs2, req_rs1,
                               req_funct3, req_rd, OPC_ALU};
                enc_illegal = req_alt && (req_funct3 != 3'b000) && (req_funct3 != 3'b101);
            end
            4'd9:  enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_FENCE};
            4'd10: enc_word = 32'h0000_0073;
            4'd11: enc_word = 32'h0010_0073;
            4'd12: enc_word = 32'h3020_0073;
            4'd13: begin
                enc_word    = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_SYSTEM};
                enc_illegal = (req_funct3 == 3'b000) || (req_funct3 == 3'b100);
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    // Full blocks new requests even when the head is leaving this cycle, so
    // req_ready depends only on registered state.
    assign req_ready   = (count_q != CNT_W'(DEPTH));
    assign instr_valid = (count_q != '0);
    assign instr_data  = instr_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign accept      = req_valid && req_ready && !flush;
    assign push        = accept && !enc_illegal;
    assign pop         = instr_valid && instr_ready && !flush;

    // FIFO next state; flush wins over any push or pop in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = enc_word;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Error pulse and saturating counter; a flushed request never counts.
    always_comb begin
        encode_error_d = accept && enc_illegal;
        error_count_d  = error_count_q;
        if (encode_error_d && (error_count_q != '1)) begin
            error_count_d = error_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            encode_error_q <= 1'b0;
            error_count_q  <= '0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            encode_error_q <= encode_error_d;
            error_count_q  <= error_count_d;
        end
    end

    assign encode_error = encode_error_q;
    assign error_count  = error_count_q;
    assign fifo_count   = count_q;

endmodule
